// File: rtl/wait_state_mem.sv
// rtl/wait_state_mem.sv - word-addressed memory with req/ready handshake and programmable wait states
//
// Purpose: slow-memory stand-in for the multi-cycle CPU. A request taken in
// IDLE is latched. The access happens WAIT_CYCLES edges later, and a
// one-cycle ready pulse follows it. The memory supports per-byte write enables
// and flags misaligned or out-of-range addresses.
//
// Parameters:
//   MEM_DEPTH    number of 32-bit words (byte addresses 0 .. 4*MEM_DEPTH-1)
//   WAIT_CYCLES  edges between acceptance and access, 0..255
//   INIT_FILE    initial image name; empty means no load
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   req      request valid, sampled only in IDLE
//   we       1 = write, 0 = read
//   be       byte enables for writes, be[0] -> bits 7:0
//   addr     byte address
//   w_data   write data
//   ready    single-cycle completion pulse
//   r_data   read data (0 after writes and errors), held until next access
//   err      access rejected, held until next access
//   busy     high whenever the FSM is not in IDLE
//
// Optional build macro MEM_STATS_EN adds rd_count, wr_count and err_count.

module wait_state_mem #(
  parameter int    MEM_DEPTH   = 1024,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] w_data,
  output logic        ready,
  output logic [31:0] r_data,
  output logic        err,
`ifdef MEM_STATS_EN
  output logic        busy,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [31:0] err_count
`else
  output logic        busy
`endif
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_we;
  logic [3:0]  lat_be;

  logic [31:0] mem [MEM_DEPTH];

  // With zero wait states the access happens on the accept edge itself, so
  // the operands come straight from the inputs instead of the latches.
  logic        fast;
  logic        do_access;
  logic        acc_we;
  logic        acc_bad;
  logic [3:0]  acc_be;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [AW-1:0] acc_idx;

  always_comb begin
    fast      = (state == S_IDLE) && req && (WAIT_CYCLES == 0);
    // Gated by reset_n so a held reset never lets a write reach the array.
    do_access = reset_n && (fast || ((state == S_WAIT) && (cnt == 8'd1)));
    acc_addr  = fast ? addr   : lat_addr;
    acc_wdata = fast ? w_data : lat_wdata;
    acc_we    = fast ? we     : lat_we;
    acc_be    = fast ? be     : lat_be;
    acc_bad   = (acc_addr[1:0] != 2'b00) ||
                ({2'b00, acc_addr[31:2]} >= 32'(MEM_DEPTH));
    acc_idx   = acc_addr[AW+1:2];
  end

  // Array has no reset; contents survive reset_n.
  always_ff @(posedge clk) begin
    if (do_access && !acc_bad && acc_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= 8'd0;
      ready     <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      r_data    <= 32'd0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_we    <= 1'b0;
      lat_be    <= 4'd0;
    end else begin
      ready <= 1'b0;
      if (do_access) begin
        if (acc_bad) begin
          r_data <= 32'd0;
          err    <= 1'b1;
        end else begin
          err    <= 1'b0;
          r_data <= acc_we ? 32'd0 : mem[acc_idx];
        end
      end
      case (state)
        S_IDLE: begin
          if (req) begin
            lat_addr  <= addr;
            lat_wdata <= w_data;
            lat_we    <= we;
            lat_be    <= be;
            cnt       <= 8'(WAIT_CYCLES);
            busy      <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state <= S_RESP;
              ready <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            state <= S_RESP;
            ready <= 1'b1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_count  <= 32'd0;
      wr_count  <= 32'd0;
      err_count <= 32'd0;
    end else if (do_access) begin
      if (acc_bad)     err_count <= err_count + 32'd1;
      else if (acc_we) wr_count  <= wr_count + 32'd1;
      else             rd_count  <= rd_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wait_state_mem.sv
// tb/tb_wait_state_mem.sv - self-checking bench for wait_state_mem at 0, 2 and 4 wait states
module tb_wait_state_mem;

  localparam int MD = 64;

  logic        clk;
  logic        reset_n;
  logic        req    [3];
  logic        we     [3];
  logic [3:0]  be     [3];
  logic [31:0] addr   [3];
  logic [31:0] w_data [3];
  logic        ready  [3];
  logic [31:0] r_data [3];
  logic        err    [3];
  logic        busy   [3];
`ifdef MEM_STATS_EN
  logic [31:0] rd_c [3];
  logic [31:0] wr_c [3];
  logic [31:0] er_c [3];
`endif

  int tests = 0;
  int fails = 0;

  logic [31:0] model [3][MD];
  logic [31:0] e_rd [3];
  logic [31:0] e_wr [3];
  logic [31:0] e_er [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    wait_state_mem #(.MEM_DEPTH(MD), .WAIT_CYCLES(2*g)) u_dut (
      .clk(clk), .reset_n(reset_n), .req(req[g]), .we(we[g]), .be(be[g]),
      .addr(addr[g]), .w_data(w_data[g]), .ready(ready[g]), .r_data(r_data[g]),
`ifdef MEM_STATS_EN
      .err(err[g]), .busy(busy[g]),
      .rd_count(rd_c[g]), .wr_count(wr_c[g]), .err_count(er_c[g])
`else
      .err(err[g]), .busy(busy[g])
`endif
    );
  end

  function automatic int wc(input int k);
    return 2 * k;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[dut%0d] observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic chk_stats(input int k);
`ifdef MEM_STATS_EN
    chk("rd_count", k, rd_c[k], e_rd[k]);
    chk("wr_count", k, wr_c[k], e_wr[k]);
    chk("err_count", k, er_c[k], e_er[k]);
`endif
  endtask

  // One transaction: drive, check busy/ready each cycle, check response
  // against the model, then confirm the bus goes idle and r_data holds.
  // While the DUT is busy, random junk (including req pulses) is driven.
  task automatic txn(input int k, input logic w, input logic [3:0] b,
                     input logic [31:0] a, input logic [31:0] d, output logic [31:0] got);
    logic [31:0] exp_r;
    logic        exp_e;
    int          idx;
    int          wcy;
    wcy = wc(k);
    @(negedge clk);
    req[k] = 1'b1; we[k] = w; be[k] = b; addr[k] = a; w_data[k] = d;
    @(posedge clk);
    #1;
    req[k] = 1'b0; we[k] = 1'($urandom); be[k] = 4'($urandom);
    addr[k] = $urandom; w_data[k] = $urandom;
    if (a[1:0] != 2'b00 || {2'b00, a[31:2]} >= 32'(MD)) begin
      exp_e = 1'b1; exp_r = 32'd0; e_er[k]++;
    end else begin
      idx = int'({2'b00, a[31:2]});
      exp_e = 1'b0;
      if (w) begin
        for (int i = 0; i < 4; i++) if (b[i]) model[k][idx][8*i +: 8] = d[8*i +: 8];
        exp_r = 32'd0; e_wr[k]++;
      end else begin
        exp_r = model[k][idx]; e_rd[k]++;
      end
    end
    for (int c = 1; c <= wcy + 1; c++) begin
      @(negedge clk);
      chk("busy", k, 32'(busy[k]), 32'd1);
      chk("ready", k, 32'(ready[k]), (c == wcy + 1) ? 32'd1 : 32'd0);
      if (c < wcy + 1) begin
        req[k] = 1'($urandom); we[k] = 1'($urandom); be[k] = 4'($urandom);
        addr[k] = $urandom; w_data[k] = $urandom;
      end else begin
        req[k] = 1'b0;
      end
    end
    chk("r_data", k, r_data[k], exp_r);
    chk("err", k, 32'(err[k]), 32'(exp_e));
    chk_stats(k);
    got = r_data[k];
    @(negedge clk);
    chk("ready_after", k, 32'(ready[k]), 32'd0);
    chk("busy_after", k, 32'(busy[k]), 32'd0);
    chk("r_data_hold", k, r_data[k], exp_r);
    chk("err_hold", k, 32'(err[k]), 32'(exp_e));
  endtask

  task automatic chk_all_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_ready"}, k, 32'(ready[k]), 32'd0);
      chk({tag, "_busy"}, k, 32'(busy[k]), 32'd0);
      chk({tag, "_err"}, k, 32'(err[k]), 32'd0);
      chk({tag, "_r_data"}, k, r_data[k], 32'd0);
      chk_stats(k);
    end
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] old;
    logic [31:0] a;
    int          r;

    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; be[k] = 4'd0; addr[k] = 32'd0; w_data[k] = 32'd0;
      e_rd[k] = 32'd0; e_wr[k] = 32'd0; e_er[k] = 32'd0;
    end
    @(negedge clk); @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;

    // Fill every word of every instance so the model is fully known.
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < MD; i++)
        txn(k, 1'b1, 4'hF, 32'(4 * i), $urandom, got);

    // Directed scenarios on the 2-wait-state instance.
    txn(1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, got);
    txn(1, 1'b0, 4'h0, 32'h10, 32'h0, got);
    chk("read_deadbeef", 1, got, 32'hDEADBEEF);
    txn(1, 1'b1, 4'hF, 32'h20, 32'h11223344, got);
    txn(1, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, got);
    txn(1, 1'b0, 4'hF, 32'h20, 32'h0, got);
    chk("byte_merge", 1, got, 32'h11BB33DD);
    txn(1, 1'b0, 4'h0, 32'h22, 32'h0, got);
    txn(1, 1'b0, 4'h0, 32'(4 * MD), 32'h0, got);
    txn(1, 1'b1, 4'h0, 32'h24, 32'h12345678, got);
    txn(1, 1'b1, 4'hF, 32'h26, 32'h12345678, got);
    txn(1, 1'b0, 4'h0, 32'h24, 32'h0, got);
    txn(1, 1'b0, 4'h0, 32'h20, 32'h0, got);
    chk("unchanged_after_err", 1, got, 32'h11BB33DD);

    // Zero wait states, req held for six cycles: a pulse every other cycle.
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'h0; addr[0] = 32'h10;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("tput_ready", 0, 32'(ready[0]), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("tput_busy", 0, 32'(busy[0]), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("tput_r_data", 0, r_data[0], model[0][4]);
    end
    req[0] = 1'b0;
    e_rd[0] = e_rd[0] + 32'd3;
    @(negedge clk);
    chk("tput_idle", 0, 32'(ready[0]), 32'd0);
    chk_stats(0);

    // Reset two cycles into a 4-wait-state write: write must be dropped.
    old = model[2][16];
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; be[2] = 4'hF; addr[2] = 32'h40; w_data[2] = 32'h55AA55AA;
    @(posedge clk);
    #1;
    req[2] = 1'b0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      e_rd[k] = 32'd0; e_wr[k] = 32'd0; e_er[k] = 32'd0;
    end
    chk_all_zero("async_reset");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset_no_ready", 2, 32'(ready[2]), 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset");
    txn(2, 1'b0, 4'h0, 32'h40, 32'h0, got);
    chk("reset_write_dropped", 2, got, old);

    // Randomized traffic on all instances against the model.
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 40; n++) begin
        r = int'($urandom_range(0, 9));
        if (r == 0)      a = 32'(4 * $urandom_range(0, MD - 1) + $urandom_range(1, 3));
        else if (r == 1) a = 32'h8000_0000 | ($urandom & 32'hFFFF_FFFC);
        else if (r == 2) a = 32'(4 * (MD + $urandom_range(0, 100)));
        else             a = 32'(4 * $urandom_range(0, MD - 1));
        txn(k, 1'($urandom), 4'($urandom), a, $urandom, got);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
